// File: rtl/mips_defs.sv
// Shared MIPS decode definitions: opcodes, functs, ALU ops, immediate-extension modes,
// ID-stage FSM states and the opcode/funct decoder used by the decode-stage controller.
package mips_defs;

  localparam int AOP_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [AOP_W-1:0] ALU_ADD  = 4'h0;
  localparam logic [AOP_W-1:0] ALU_SUB  = 4'h1;
  localparam logic [AOP_W-1:0] ALU_AND  = 4'h2;
  localparam logic [AOP_W-1:0] ALU_OR   = 4'h3;
  localparam logic [AOP_W-1:0] ALU_XOR  = 4'h4;
  localparam logic [AOP_W-1:0] ALU_NOR  = 4'h5;
  localparam logic [AOP_W-1:0] ALU_SLT  = 4'h6;
  localparam logic [AOP_W-1:0] ALU_SLTU = 4'h7;
  localparam logic [AOP_W-1:0] ALU_SLL  = 4'h8;
  localparam logic [AOP_W-1:0] ALU_SRL  = 4'h9;
  localparam logic [AOP_W-1:0] ALU_SRA  = 4'hA;
  localparam logic [AOP_W-1:0] ALU_LUI  = 4'hB;

  typedef enum logic [1:0] {
    EXT_SIGN  = 2'd0,
    EXT_ZERO  = 2'd1,
    EXT_UPPER = 2'd2,
    EXT_NONE  = 2'd3
  } ext_mode_e;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

  typedef struct packed {
    logic             alusrc;
    logic             regdst;
    logic             memread;
    logic             memwrite;
    logic             regwrite;
    logic             branch;
    logic             illegal;
    logic             use_rs;
    logic             use_rt;
    logic [AOP_W-1:0] aluop;
    ext_mode_e        ext;
  } dec_t;

  // Undecoded encodings collapse to a NOP that only raises illegal and reads no registers.
  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
    dec_t d;
    logic ok;
    d        = '0;
    d.ext    = EXT_SIGN;
    d.use_rs = 1'b1;
    ok       = 1'b1;
    case (op)
      OP_RTYPE: begin
        d.regdst   = 1'b1;
        d.regwrite = 1'b1;
        d.use_rt   = 1'b1;
        d.ext      = EXT_NONE;
        case (fn)
          FN_ADD, FN_ADDU: d.aluop = ALU_ADD;
          FN_SUB, FN_SUBU: d.aluop = ALU_SUB;
          FN_AND:          d.aluop = ALU_AND;
          FN_OR:           d.aluop = ALU_OR;
          FN_XOR:          d.aluop = ALU_XOR;
          FN_NOR:          d.aluop = ALU_NOR;
          FN_SLT:          d.aluop = ALU_SLT;
          FN_SLTU:         d.aluop = ALU_SLTU;
          FN_SLL:          d.aluop = ALU_SLL;
          FN_SRL:          d.aluop = ALU_SRL;
          FN_SRA:          d.aluop = ALU_SRA;
          default:         ok = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin d.alusrc = 1'b1; d.regwrite = 1'b1; d.aluop = ALU_ADD; end
      OP_SLTI:  begin d.alusrc = 1'b1; d.regwrite = 1'b1; d.aluop = ALU_SLT;  end
      OP_SLTIU: begin d.alusrc = 1'b1; d.regwrite = 1'b1; d.aluop = ALU_SLTU; end
      OP_ANDI:  begin d.alusrc = 1'b1; d.regwrite = 1'b1; d.aluop = ALU_AND; d.ext = EXT_ZERO; end
      OP_ORI:   begin d.alusrc = 1'b1; d.regwrite = 1'b1; d.aluop = ALU_OR;  d.ext = EXT_ZERO; end
      OP_XORI:  begin d.alusrc = 1'b1; d.regwrite = 1'b1; d.aluop = ALU_XOR; d.ext = EXT_ZERO; end
      OP_LUI: begin
        d.alusrc   = 1'b1;
        d.regwrite = 1'b1;
        d.aluop    = ALU_LUI;
        d.ext      = EXT_UPPER;
        d.use_rs   = 1'b0;
      end
      OP_LW: begin d.alusrc = 1'b1; d.memread = 1'b1; d.regwrite = 1'b1; d.aluop = ALU_ADD; end
      OP_SW: begin d.alusrc = 1'b1; d.memwrite = 1'b1; d.use_rt = 1'b1; d.aluop = ALU_ADD; end
      OP_BEQ, OP_BNE: begin d.branch = 1'b1; d.use_rt = 1'b1; d.aluop = ALU_SUB; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      d         = '0;
      d.illegal = 1'b1;
      d.ext     = EXT_NONE;
    end
    return d;
  endfunction

endpackage

// File: rtl/id_stage_ctrl_if.sv
// IF-side request, EX-side hazard inputs and ID/EX outputs of the decode-stage controller.
// Optional stall_count signal present when ID_STALL_CNT_EN is defined.
interface id_stage_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int AOP_W = 4
);
  logic             if_valid;
  logic [XLEN-1:0]  if_instr;
  logic [XLEN-1:0]  if_pc;
  logic             flush;
  logic             ex_memread;
  logic [4:0]       ex_rt;
  logic             stall_if;
  logic             id_valid;
  logic [XLEN-1:0]  id_pc;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rd;
  logic [XLEN-1:0]  id_imm_ext;
  logic             id_ext_sign;
  logic             id_alusrc;
  logic             id_regdst;
  logic             id_memread;
  logic             id_memwrite;
  logic             id_regwrite;
  logic             id_branch;
  logic [AOP_W-1:0] id_aluop;
  logic             id_illegal;
`ifdef ID_STALL_CNT_EN
  logic [31:0]      stall_count;
`endif

  modport master (
    output if_valid, if_instr, if_pc, flush, ex_memread, ex_rt,
    input  stall_if, id_valid, id_pc, id_rs, id_rt, id_rd, id_imm_ext, id_ext_sign,
           id_alusrc, id_regdst, id_memread, id_memwrite, id_regwrite, id_branch,
           id_aluop, id_illegal
`ifdef ID_STALL_CNT_EN
    , input stall_count
`endif
  );

  modport slave (
    input  if_valid, if_instr, if_pc, flush, ex_memread, ex_rt,
    output stall_if, id_valid, id_pc, id_rs, id_rt, id_rd, id_imm_ext, id_ext_sign,
           id_alusrc, id_regdst, id_memread, id_memwrite, id_regwrite, id_branch,
           id_aluop, id_illegal
`ifdef ID_STALL_CNT_EN
    , output stall_count
`endif
  );
endinterface

// File: rtl/imm_ext_unit.sv
// Combinational immediate extender: sign, zero, upper-half placement, or zero for R-type.
module imm_ext_unit
  import mips_defs::*;
#(
  parameter int XLEN  = 32,
  parameter int IMM_W = 16
) (
  input  logic [IMM_W-1:0] i_imm,
  input  ext_mode_e        i_mode,
  output logic [XLEN-1:0]  o_ext
);
  always_comb begin
    o_ext = '0;
    case (i_mode)
      EXT_SIGN:  o_ext = {{(XLEN-IMM_W){i_imm[IMM_W-1]}}, i_imm};
      EXT_ZERO:  o_ext = {{(XLEN-IMM_W){1'b0}}, i_imm};
      EXT_UPPER: o_ext = {i_imm, {(XLEN-IMM_W){1'b0}}};
      default:   o_ext = '0;
    endcase
  end
endmodule

// File: rtl/id_stage_ctrl.sv
// MIPS decode stage: IF/ID register, opcode decode, load-use stall FSM and ID/EX register.
// Define ID_STALL_CNT_EN to add a saturating count of load-use bubbles on stall_count.
module id_stage_ctrl #(
  parameter int XLEN  = 32,
  parameter int IMM_W = 16,
  parameter int AOP_W = mips_defs::AOP_W
) (
  input logic           clk,
  input logic           rst,
  id_stage_ctrl_if.slave bus
);
  import mips_defs::*;

  logic            r_ifid_valid;
  logic [XLEN-1:0] r_ifid_instr;
  logic [XLEN-1:0] r_ifid_pc;
  state_e          r_state;
  state_e          w_state_nxt;
  dec_t            w_dec;
  logic [4:0]      w_rs, w_rt, w_rd;
  logic [XLEN-1:0] w_imm_ext;
  logic            w_hazard, w_stall, w_issue;

  assign w_rs  = r_ifid_instr[25:21];
  assign w_rt  = r_ifid_instr[20:16];
  assign w_rd  = r_ifid_instr[15:11];
  assign w_dec = decode(r_ifid_instr[31:26], r_ifid_instr[5:0]);

  assign w_hazard = r_ifid_valid && bus.ex_memread && (bus.ex_rt != 5'd0) &&
                    ((w_dec.use_rs && (w_rs == bus.ex_rt)) ||
                     (w_dec.use_rt && (w_rt == bus.ex_rt)));

  // Flush and reset override any stall decision and force the FSM back to RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      RUN: begin
        if (w_hazard) begin
          w_stall     = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (w_hazard) w_stall = 1'b1;
        else          w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
    if (bus.flush || rst) begin
      w_stall     = 1'b0;
      w_state_nxt = RUN;
    end
  end

  assign bus.stall_if = w_stall;
  assign w_issue      = r_ifid_valid && !w_stall && !bus.flush;

  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  // IF/ID stage
  always_ff @(posedge clk) begin
    if (rst || bus.flush) r_ifid_valid <= 1'b0;
    else if (!w_stall)    r_ifid_valid <= bus.if_valid;
  end

  always_ff @(posedge clk) begin
    if (!w_stall) begin
      r_ifid_instr <= bus.if_instr;
      r_ifid_pc    <= bus.if_pc;
    end
  end

  imm_ext_unit #(.XLEN(XLEN), .IMM_W(IMM_W)) u_imm_ext (
    .i_imm  (r_ifid_instr[IMM_W-1:0]),
    .i_mode (w_dec.ext),
    .o_ext  (w_imm_ext)
  );

  // ID/EX stage: bubbles clear every field, not only the enables.
  always_ff @(posedge clk) begin
    if (rst || !w_issue) begin
      bus.id_valid    <= 1'b0;
      bus.id_pc       <= '0;
      bus.id_rs       <= '0;
      bus.id_rt       <= '0;
      bus.id_rd       <= '0;
      bus.id_imm_ext  <= '0;
      bus.id_ext_sign <= 1'b0;
      bus.id_alusrc   <= 1'b0;
      bus.id_regdst   <= 1'b0;
      bus.id_memread  <= 1'b0;
      bus.id_memwrite <= 1'b0;
      bus.id_regwrite <= 1'b0;
      bus.id_branch   <= 1'b0;
      bus.id_aluop    <= '0;
      bus.id_illegal  <= 1'b0;
    end else begin
      bus.id_valid    <= 1'b1;
      bus.id_pc       <= r_ifid_pc;
      bus.id_rs       <= w_rs;
      bus.id_rt       <= w_rt;
      bus.id_rd       <= w_rd;
      bus.id_imm_ext  <= w_imm_ext;
      bus.id_ext_sign <= (w_dec.ext == EXT_SIGN);
      bus.id_alusrc   <= w_dec.alusrc;
      bus.id_regdst   <= w_dec.regdst;
      bus.id_memread  <= w_dec.memread;
      bus.id_memwrite <= w_dec.memwrite;
      bus.id_regwrite <= w_dec.regwrite;
      bus.id_branch   <= w_dec.branch;
      bus.id_aluop    <= w_dec.aluop;
      bus.id_illegal  <= w_dec.illegal;
    end
  end

`ifdef ID_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst)                                   r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != '1))   r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign bus.stall_count = r_stall_cnt;
`endif

endmodule
